// File: rtl/alu_divider_param.sv
// Multi-cycle restoring divider with start/busy/done handshake.
// Signed operation divides magnitudes and fixes signs afterwards.
module alu_divider_param #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] accR;
    logic [WIDTH-1:0] quoR;
    logic [WIDTH-1:0] magDivisor;
    logic [CW-1:0]    cnt;
    logic             negQ;
    logic             negR;
    logic             fixPhase;

    logic             accept;
    logic             signedOp;
    logic             dvdNeg;
    logic             dvsNeg;
    logic [WIDTH-1:0] dvdMag;
    logic [WIDTH-1:0] dvsMag;
    logic [WIDTH:0]   accShift;
    logic             fits;
    logic [WIDTH-1:0] accSub;

    assign accept   = start && (state == IDLE || state == DONE);
    assign signedOp = SIGNED_EN && is_signed;
    assign dvdNeg   = signedOp && dividend[WIDTH-1];
    assign dvsNeg   = signedOp && divisor[WIDTH-1];
    assign dvdMag   = dvdNeg ? -dividend : dividend;
    assign dvsMag   = dvsNeg ? -divisor : divisor;

    // Partial remainder needs one extra bit only for the compare;
    // after subtraction the result always fits in WIDTH bits.
    assign accShift = {accR, quoR[WIDTH-1]};
    assign fits     = accShift >= {1'b0, magDivisor};
    assign accSub   = accShift[WIDTH-1:0] - magDivisor;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            accR        <= '0;
            quoR        <= '0;
            magDivisor  <= '0;
            cnt         <= '0;
            negQ        <= 1'b0;
            negR        <= 1'b0;
            fixPhase    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_by_zero <= 1'b0;
                negQ        <= dvdNeg ^ dvsNeg;
                negR        <= dvdNeg;
                accR        <= '0;
                quoR        <= dvdMag;
                magDivisor  <= dvsMag;
                cnt         <= CW'(WIDTH - 1);
                fixPhase    <= 1'b0;
                if (divisor == '0) begin
                    state       <= DONE;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    state <= CALC;
                    busy  <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    CALC: begin
                        accR <= fits ? accSub : accShift[WIDTH-1:0];
                        quoR <= {quoR[WIDTH-2:0], fits};
                        if (cnt == '0) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    FIX: begin
                        // Negate first, publish on the following edge.
                        if (!fixPhase) begin
                            quoR     <= negQ ? -quoR : quoR;
                            accR     <= negR ? -accR : accR;
                            fixPhase <= 1'b1;
                        end else begin
                            quotient  <= quoR;
                            remainder <= accR;
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_divider_param.sv
// Directed-vector bench for alu_divider_param at WIDTH=32.
// Each task drives one scenario and checks its own results.
module tb_alu_divider_param;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int nCompared;
    int nMismatched;
    int edges;

    alu_divider_param #(
        .WIDTH    (32),
        .SIGNED_EN(1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a start for one edge, then scramble operands.
    task automatic startOp(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0000;
        is_signed = ~sgn;
    endtask

    // Edges after the accepting edge until done is seen (-1 on timeout).
    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
        end
        nCompared++;
        if (quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_out q=%h r=%h z=%b want 0 0 0",
                     quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned;
        startOp(1'b0, 32'd100, 32'd7);
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL u_busy got=%b want 1", busy);
        end
        waitDone(edges);
        nCompared++;
        if (edges !== 34) begin
            nMismatched++;
            $display("FAIL u_latency got=%0d want 34", edges);
        end
        nCompared++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            nMismatched++;
            $display("FAIL u_100_7 q=%h r=%h z=%b want e 2 0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        nCompared++;
        if (done !== 1'b0 || quotient !== 32'd14) begin
            nMismatched++;
            $display("FAIL u_pulse done=%b q=%h want 0 e", done, quotient);
        end
    endtask

    task automatic test_signed;
        startOp(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitDone(edges);
        nCompared++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            nMismatched++;
            $display("FAIL s_m7_2 q=%h r=%h want fffffffd ffffffff",
                     quotient, remainder);
        end
        startOp(1'b1, 32'd7, 32'hFFFF_FFFE);
        waitDone(edges);
        nCompared++;
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
            nMismatched++;
            $display("FAIL s_7_m2 q=%h r=%h want fffffffd 1", quotient, remainder);
        end
        startOp(1'b0, 32'hFFFF_FFF9, 32'd2);
        waitDone(edges);
        nCompared++;
        if (quotient !== 32'h7FFF_FFFC || remainder !== 32'd1) begin
            nMismatched++;
            $display("FAIL s_unsig q=%h r=%h want 7ffffffc 1", quotient, remainder);
        end
    endtask

    task automatic test_div_zero;
        startOp(1'b0, 32'h0000_1234, 32'd0);
        nCompared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL z_latency done=%b busy=%b want 1 0", done, busy);
        end
        nCompared++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234 || div_by_zero !== 1'b1) begin
            nMismatched++;
            $display("FAIL z_result q=%h r=%h z=%b want ffffffff 1234 1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_overflow;
        startOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        nCompared++;
        if (div_by_zero !== 1'b0) begin
            nMismatched++;
            $display("FAIL o_flagclr got=%b want 0", div_by_zero);
        end
        waitDone(edges);
        nCompared++;
        if (quotient !== 32'h8000_0000 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            nMismatched++;
            $display("FAIL o_min_m1 q=%h r=%h z=%b want 80000000 0 0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        startOp(1'b0, 32'd1000, 32'd10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        nCompared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL b_ignore busy=%b done=%b want 1 0", busy, done);
        end
        waitDone(edges);
        nCompared++;
        if (edges !== 29 || quotient !== 32'd100 || remainder !== 32'd0) begin
            nMismatched++;
            $display("FAIL b_first n=%0d q=%h r=%h want 29 64 0",
                     edges, quotient, remainder);
        end
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd77;
        divisor   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        nCompared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("FAIL b_accept busy=%b done=%b want 1 0", busy, done);
        end
        waitDone(edges);
        nCompared++;
        if (edges !== 34 || quotient !== 32'd15 || remainder !== 32'd2) begin
            nMismatched++;
            $display("FAIL b_second n=%0d q=%h r=%h want 34 f 2",
                     edges, quotient, remainder);
        end
    endtask

    task automatic test_reset_abort;
        int doneSeen;
        startOp(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'h0 ||
            remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            nMismatched++;
            $display("FAIL a_reset busy=%b done=%b q=%h r=%h z=%b want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        nCompared++;
        if (doneSeen !== 0) begin
            nMismatched++;
            $display("FAIL a_nodone got=%0d want 0", doneSeen);
        end
        startOp(1'b0, 32'hFFFF_FFFF, 32'd1);
        waitDone(edges);
        nCompared++;
        if (edges !== 34 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h0) begin
            nMismatched++;
            $display("FAIL a_max_1 n=%0d q=%h r=%h want 34 ffffffff 0",
                     edges, quotient, remainder);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        is_signed   = 1'b0;
        dividend    = 32'h0;
        divisor     = 32'h0;
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
